// File: rtl/toggle_event_decoder.sv
// rtl/toggle_event_decoder.sv - toggle-encoded event decoder with pending buffer and valid/ready output
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int TOT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tog_in,
  input  logic             ev_ready,
  input  logic             clr_ovf,
  output logic             ev_valid,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic [TOT_W-1:0] total_cnt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   tog_prev_q, tog_prev_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic [TOT_W-1:0]       total_cnt_q, total_cnt_d;

  logic tog_s;
  logic det;
  logic take;
  logic full;

  assign tog_s    = sync_q[SYNC_STAGES-1];
  assign det      = tog_s ^ tog_prev_q;
  assign ev_valid = (pending_q != '0);
  assign take     = ev_valid && ev_ready;
  assign full     = &pending_q;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], tog_in};
    tog_prev_d  = tog_s;
    pending_d   = pending_q;
    overflow_d  = overflow_q;
    total_cnt_d = total_cnt_q + TOT_W'(det);

    if (clr_ovf) overflow_d = 1'b0;

    // A simultaneous detect and consume leaves the count unchanged, even when full.
    unique case ({det, take})
      2'b01: pending_d = pending_q - CNT_W'(1);
      2'b10: begin
        if (full) overflow_d = 1'b1;
        else      pending_d  = pending_q + CNT_W'(1);
      end
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      tog_prev_q  <= 1'b0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      total_cnt_q <= '0;
    end else begin
      sync_q      <= sync_d;
      tog_prev_q  <= tog_prev_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      total_cnt_q <= total_cnt_d;
    end
  end

  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign total_cnt = total_cnt_q;

endmodule
